// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer core.
// Contents: instruction field positions, opcode constants and the
// sequencer state enumeration. No ports.
package led_seq_pkg;

    // Instruction word layout: op in the top nibble, operand below it.
    localparam int INSTR_W = 32;
    localparam int OP_HI   = 31;
    localparam int OP_LO   = 28;
    localparam int OPND_W  = 28;
    localparam int LC_W    = 16;
    localparam int DISP_W  = 16;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_SETG   = 4'd1;
    localparam logic [3:0] OP_SETR   = 4'd2;
    localparam logic [3:0] OP_SETHEX = 4'd3;
    localparam logic [3:0] OP_JMP    = 4'd4;
    localparam logic [3:0] OP_WAIT   = 4'd5;
    localparam logic [3:0] OP_LDC    = 4'd6;
    localparam logic [3:0] OP_DJNZ   = 4'd7;
    localparam logic [3:0] OP_HALT   = 4'd8;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

endpackage

// File: rtl/SEG7_LUT.sv
// Hex digit to 7-segment decoder, active-low outputs.
// Ports:
//   dig_i [3:0]  hex nibble
//   seg_o [6:0]  segments {g,f,e,d,c,b,a}, 0 = segment lit
module SEG7_LUT (
    input  logic [3:0] dig_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'b1111111;
        case (dig_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/led_seq_core.sv
// LED sequencer core: fetches 32-bit instructions from a synchronous
// instruction memory and executes LED/HEX writes, jumps, waits, a
// hardware loop counter and halt.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   run               1 = execute, 0 = pause at next FETCH
//   imem_addr         instruction address (= pc)
//   imem_rdata        instruction word, valid one cycle after imem_addr
//   outLedG, outLedR  green / red LED banks
//   out7Seg0..3       active-low digits, digit0 = disp[3:0]
//   halted            high while in HALT
//   illegal           sticky undefined-opcode flag
module led_seq_core
    import led_seq_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEDG_W = 8,
    parameter int LEDR_W = 10,
    parameter int WAIT_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [LEDG_W-1:0] outLedG,
    output logic [LEDR_W-1:0] outLedR,
    output logic [6:0]        out7Seg0,
    output logic [6:0]        out7Seg1,
    output logic [6:0]        out7Seg2,
    output logic [6:0]        out7Seg3,
    output logic              halted,
    output logic              illegal
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [LEDG_W-1:0]   ledg_q, ledg_d;
    logic [LEDR_W-1:0]   ledr_q, ledr_d;
    logic [DISP_W-1:0]   disp_q, disp_d;
    logic [LC_W-1:0]     lc_q, lc_d;
    logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
    logic                illegal_q, illegal_d;

    logic [3:0]          op;
    logic [WAIT_W-1:0]   wait_n;
    logic [LC_W-1:0]     lc_dec;
    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   target;
    logic                unused_rdata;

    assign op     = imem_rdata[OP_HI:OP_LO];
    assign wait_n = imem_rdata[WAIT_W-1:0];
    assign target = imem_rdata[ADDR_W-1:0];
    assign lc_dec = lc_q - LC_W'(1);
    // Natural truncation gives the modulo-2^ADDR_W wrap.
    assign pc_inc = pc_q + ADDR_W'(1);
    // Operand bits above the widest field in use are ignored by design.
    assign unused_rdata = ^imem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= '0;
            ledg_q    <= '0;
            ledr_q    <= '0;
            disp_q    <= '0;
            lc_q      <= '0;
            wcnt_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ledg_q    <= ledg_d;
            ledr_q    <= ledr_d;
            disp_q    <= disp_d;
            lc_q      <= lc_d;
            wcnt_q    <= wcnt_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ledg_d    = ledg_q;
        ledr_d    = ledr_q;
        disp_d    = disp_q;
        lc_d      = lc_q;
        wcnt_d    = wcnt_q;
        illegal_d = illegal_q;

        case (state_q)
            ST_FETCH: begin
                // The memory presents the word for pc during the next cycle.
                if (run) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                pc_d    = pc_inc;
                state_d = ST_FETCH;
                case (op)
                    OP_NOP:    ;
                    OP_SETG:   ledg_d = imem_rdata[LEDG_W-1:0];
                    OP_SETR:   ledr_d = imem_rdata[LEDR_W-1:0];
                    OP_SETHEX: disp_d = imem_rdata[DISP_W-1:0];
                    OP_JMP:    pc_d   = target;
                    OP_WAIT: begin
                        // A zero count degenerates to a NOP.
                        if (wait_n != '0) begin
                            wcnt_d  = wait_n;
                            state_d = ST_WAIT;
                        end
                    end
                    OP_LDC:    lc_d = imem_rdata[LC_W-1:0];
                    OP_DJNZ: begin
                        lc_d = lc_dec;
                        if (lc_dec != '0) pc_d = target;
                    end
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = ST_HALT;
                    end
                    default:   illegal_d = 1'b1;
                endcase
            end
            ST_WAIT: begin
                // Leaving on a count of 1 makes WAIT n occupy exactly n cycles.
                wcnt_d = wcnt_q - WAIT_W'(1);
                if (wcnt_q <= WAIT_W'(1)) state_d = ST_FETCH;
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    assign imem_addr = pc_q;
    assign outLedG   = ledg_q;
    assign outLedR   = ledr_q;
    assign halted    = (state_q == ST_HALT);
    assign illegal   = illegal_q;

    SEG7_LUT u_seg0 (.dig_i(disp_q[3:0]),   .seg_o(out7Seg0));
    SEG7_LUT u_seg1 (.dig_i(disp_q[7:4]),   .seg_o(out7Seg1));
    SEG7_LUT u_seg2 (.dig_i(disp_q[11:8]),  .seg_o(out7Seg2));
    SEG7_LUT u_seg3 (.dig_i(disp_q[15:12]), .seg_o(out7Seg3));

endmodule

// File: tb/tb_led_seq_core.sv
module tb_led_seq_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b1;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [7:0]  outLedG;
    logic [9:0]  outLedR;
    logic [6:0]  out7Seg0, out7Seg1, out7Seg2, out7Seg3;
    logic        halted, illegal;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [256];

    // Reference architectural state
    logic [7:0]  m_pc;
    logic [7:0]  m_ledg;
    logic [9:0]  m_ledr;
    logic [15:0] m_disp;
    logic [15:0] m_lc;
    logic        m_halt;
    logic        m_ill;

    led_seq_core #(.ADDR_W(8), .LEDG_W(8), .LEDR_W(10), .WAIT_W(24)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .outLedG(outLedG), .outLedR(outLedR),
        .out7Seg0(out7Seg0), .out7Seg1(out7Seg1),
        .out7Seg2(out7Seg2), .out7Seg3(out7Seg3),
        .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: word appears one cycle after address.
    always @(posedge clk) imem_rdata <= mem[imem_addr];

    // Segment shapes written active-high (gfedcba), then inverted.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] lit;
        case (d)
            4'h0: lit = 7'h3F; 4'h1: lit = 7'h06; 4'h2: lit = 7'h5B; 4'h3: lit = 7'h4F;
            4'h4: lit = 7'h66; 4'h5: lit = 7'h6D; 4'h6: lit = 7'h7D; 4'h7: lit = 7'h07;
            4'h8: lit = 7'h7F; 4'h9: lit = 7'h6F; 4'hA: lit = 7'h77; 4'hB: lit = 7'h7C;
            4'hC: lit = 7'h39; 4'hD: lit = 7'h5E; 4'hE: lit = 7'h79; default: lit = 7'h71;
        endcase
        return ~lit;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".addr"},    32'(imem_addr), 32'(m_pc));
        chk({where, ".ledg"},    32'(outLedG),   32'(m_ledg));
        chk({where, ".ledr"},    32'(outLedR),   32'(m_ledr));
        chk({where, ".seg0"},    32'(out7Seg0),  32'(seg_of(m_disp[3:0])));
        chk({where, ".seg1"},    32'(out7Seg1),  32'(seg_of(m_disp[7:4])));
        chk({where, ".seg2"},    32'(out7Seg2),  32'(seg_of(m_disp[11:8])));
        chk({where, ".seg3"},    32'(out7Seg3),  32'(seg_of(m_disp[15:12])));
        chk({where, ".halted"},  32'(halted),    32'(m_halt));
        chk({where, ".illegal"}, 32'(illegal),   32'(m_ill));
    endtask

    task automatic model_reset();
        m_pc = 0; m_ledg = 0; m_ledr = 0; m_disp = 0; m_lc = 0;
        m_halt = 0; m_ill = 0;
    endtask

    // Assert reset between clock edges, check the abort values, then release.
    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ISA-level interpreter: returns the extra stall cycles of the instruction.
    task automatic model_exec(input logic [31:0] w, output int n);
        logic [7:0] npc;
        n   = 0;
        npc = m_pc + 8'd1;
        case (w[31:28])
            4'd0: ;
            4'd1: m_ledg = w[7:0];
            4'd2: m_ledr = w[9:0];
            4'd3: m_disp = w[15:0];
            4'd4: npc = w[7:0];
            4'd5: n = int'(w[23:0]);
            4'd6: m_lc = w[15:0];
            4'd7: begin
                m_lc = m_lc - 16'd1;
                if (m_lc != 0) npc = w[7:0];
            end
            4'd8: begin m_halt = 1'b1; npc = m_pc; end
            default: m_ill = 1'b1;
        endcase
        m_pc = npc;
    endtask

    // Called at a negedge with the core in FETCH.
    task automatic run_instr();
        logic [31:0] w;
        int n;
        if ($urandom_range(0, 9) == 0) run = 1'b0;
        if (run == 1'b0) begin
            repeat ($urandom_range(1, 3)) begin
                check_all("pause");
                @(negedge clk);
            end
            run = 1'b1;
        end
        check_all("fetch");
        w = mem[m_pc];
        @(negedge clk);
        check_all("exec");      // effects must not be visible yet
        model_exec(w, n);
        if (n > 0 && $urandom_range(0, 1) == 1) run = 1'b0;
        @(negedge clk);
        repeat (n) begin
            check_all("wait");
            @(negedge clk);
        end
    endtask

    task automatic run_prog(input int max_steps);
        for (int i = 0; i < max_steps && !m_halt; i++) run_instr();
        if (m_halt) begin
            repeat (3) begin
                check_all("halt");
                @(negedge clk);
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        int r;
        logic [3:0]  op;
        logic [27:0] o;
        r = $urandom_range(0, 99);
        o = 28'($urandom);
        if (r < 15)      op = 4'd1;
        else if (r < 30) op = 4'd2;
        else if (r < 42) op = 4'd3;
        else if (r < 50) op = 4'd4;
        else if (r < 62) begin op = 4'd5; o = {o[27:24], 21'd0, o[2:0]}; end
        else if (r < 70) begin op = 4'd6; o[15:0] = 16'($urandom_range(0, 4)); end
        else if (r < 80) op = 4'd7;
        else if (r < 82) op = 4'd8;
        else if (r < 88) op = 4'($urandom_range(9, 15));
        else             op = 4'd0;
        return {op, o};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h8000_0000;
    endtask

    initial begin
        clear_mem();
        model_reset();

        // Basic LED writes followed by halt; pc must freeze at 2.
        mem[0] = 32'h1000_00A5;
        mem[1] = 32'h2000_03FF;
        mem[2] = 32'h8000_0000;
        do_reset();
        run_prog(10);
        chk("halt_pc", 32'(imem_addr), 32'd2);

        // Hex display, then reset in the middle of a long wait.
        clear_mem();
        mem[0] = 32'h3000_1234;
        mem[1] = 32'h1000_005A;
        mem[2] = 32'h5000_0014;
        do_reset();
        run_prog(2);
        repeat (6) @(negedge clk);
        do_reset();

        // Wait timing, zero wait, then halt.
        clear_mem();
        mem[0] = 32'h5000_0005;
        mem[1] = 32'h1000_0001;
        mem[2] = 32'h5000_0000;
        mem[3] = 32'h1000_0002;
        mem[4] = 32'h8000_0000;
        do_reset();
        run_prog(10);

        // Hardware loop of 3, then LDC 0 / DJNZ wrapping lc to FFFF.
        clear_mem();
        mem[0] = 32'h6000_0003;
        mem[1] = 32'h3000_00C3;
        mem[2] = 32'h7000_0001;
        mem[3] = 32'h6000_0000;
        mem[4] = 32'h7000_0006;
        mem[5] = 32'h8000_0000;
        mem[6] = 32'h2000_0155;
        mem[7] = 32'h8000_0000;
        do_reset();
        run_prog(20);

        // Illegal opcode, pc wrap at 255 and a self jump.
        clear_mem();
        mem[0]   = 32'hB000_0000;
        mem[1]   = 32'h1000_003C;
        mem[2]   = 32'h4000_00FF;
        mem[255] = 32'h0000_0000;
        mem[3]   = 32'h4000_0003;
        do_reset();
        run_prog(9);
        mem[0] = 32'h4000_0003;
        run_prog(6);

        // Random programs.
        for (int p = 0; p < 10; p++) begin
            for (int i = 0; i < 256; i++) mem[i] = rand_instr();
            do_reset();
            run_prog(60);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
